qkv_pass_scheduler: RTL and testbench

QKV_PASS_SCHEDULER -- requirements
Module: qkv_pass_scheduler

---
 rtl/qkv_pass_scheduler_pkg.sv | 29 ++
 rtl/qkv_pass_scheduler_tile_counter.sv | 90 +++++++++
 rtl/qkv_pass_scheduler.sv | 132 +++++++++++++
 tb/tb_qkv_pass_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qkv_pass_scheduler_pkg.sv
// Shared attention types: scheduler states, Q/K/V matrix codes,
// matrices-per-head constant and the tile-width clamp helper.
package qkv_pass_scheduler_pkg;

    localparam int MATS_PER_HEAD = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        MAT_Q = 2'd0,
        MAT_K = 2'd1,
        MAT_V = 2'd2
    } mat_t;

    function automatic logic [15:0] min_u16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/qkv_pass_scheduler_tile_counter.sv
// Pass iterator: remaining columns, column offset, matrix and head,
// plus the clamped pass width and the pass base address.
module qkv_tile_counter
    import qkv_pass_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int HEAD_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    input  logic                  adv_i,
    input  logic [15:0]           size_i,
    input  logic [15:0]           tile_w_i,
    input  logic [HEAD_W-1:0]     heads_i,
    output logic [15:0]           cols_o,
    output mat_t                  mat_o,
    output logic [HEAD_W-1:0]     head_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [15:0]           rem_q, rem_d;
    logic [15:0]           off_q, off_d;
    mat_t                  mat_q, mat_d;
    logic [HEAD_W-1:0]     head_q, head_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]           rem_left;
    logic                  mat_end;
    logic                  mat_last;

    assign cols_o   = min_u16(rem_q, tile_w_i);
    assign rem_left = rem_q - cols_o;
    assign mat_end  = (rem_left == 16'd0);
    assign mat_last = (mat_q == mat_t'(MATS_PER_HEAD - 1));
    assign last_o   = mat_end && mat_last
                   && (head_q == (heads_i - HEAD_W'(1)));

    // base_q tracks (head*3 + mat)*size by accumulation, so no multiplier
    assign addr_o = base_q + ADDR_WIDTH'(off_q);
    assign mat_o  = mat_q;
    assign head_o = head_q;

    always_comb begin
        rem_d  = rem_q;
        off_d  = off_q;
        mat_d  = mat_q;
        head_d = head_q;
        base_d = base_q;
        if (init_i) begin
            rem_d  = size_i;
            off_d  = '0;
            mat_d  = MAT_Q;
            head_d = '0;
            base_d = '0;
        end else if (adv_i && !last_o) begin
            if (mat_end) begin
                rem_d  = size_i;
                off_d  = '0;
                base_d = base_q + ADDR_WIDTH'(size_i);
                if (mat_last) begin
                    mat_d  = MAT_Q;
                    head_d = head_q + HEAD_W'(1);
                end else begin
                    mat_d = mat_t'(mat_q + 2'd1);
                end
            end else begin
                rem_d = rem_left;
                off_d = off_q + cols_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            off_q  <= '0;
            mat_q  <= MAT_Q;
            head_q <= '0;
            base_q <= '0;
        end else begin
            rem_q  <= rem_d;
            off_q  <= off_d;
            mat_q  <= mat_d;
            head_q <= head_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/qkv_pass_scheduler.sv
// Q/K/V projection pass scheduler: splits each head's Q, K and V
// matrices into PE-array tiles and sequences one pass at a time.
module qkv_pass_scheduler
    import qkv_pass_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int HEAD_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [HEAD_W-1:0]     num_heads,
    input  logic [15:0]           size_of_wq,
    input  logic [7:0]            num_pes,
    input  logic [7:0]            num_macs,
    output logic                  pe_start,
    input  logic                  pe_done,
    output logic [15:0]           workload_cols,
    output logic [1:0]            mat_sel,
    output logic [HEAD_W-1:0]     head_idx,
    output logic [ADDR_WIDTH-1:0] weight_base,
    output logic [ADDR_WIDTH-1:0] output_base,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    sched_state_t          state_q, state_d;
    logic [HEAD_W-1:0]     heads_q;
    logic [15:0]           size_q;
    logic [7:0]            pes_q, macs_q;
    logic                  cfg_err_q, cfg_err_d;
    logic [15:0]           tile_w;
    logic                  cfg_bad;
    logic                  init, adv, last;
    logic                  accept;
    mat_t                  mat_w;
    logic [ADDR_WIDTH-1:0] addr_w;

    assign tile_w  = 16'(pes_q) * 16'(macs_q);
    assign cfg_bad = (heads_q == '0) || (size_q == '0) || (tile_w == '0);
    assign accept  = (state_q == S_IDLE) && start;

    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        init      = 1'b0;
        adv       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    cfg_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (cfg_bad) begin
                    state_d   = S_DONE;
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    init    = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (pe_done) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                adv     = 1'b1;
                state_d = last ? S_DONE : S_ISSUE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort wins over everything, including a same-cycle pe_done
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cfg_err_d = cfg_err_q;
            init      = 1'b0;
            adv       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_err_q <= 1'b0;
            heads_q   <= '0;
            size_q    <= '0;
            pes_q     <= '0;
            macs_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            if (accept) begin
                heads_q <= num_heads;
                size_q  <= size_of_wq;
                pes_q   <= num_pes;
                macs_q  <= num_macs;
            end
        end
    end

    qkv_tile_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HEAD_W     (HEAD_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_i   (init),
        .adv_i    (adv),
        .size_i   (size_q),
        .tile_w_i (tile_w),
        .heads_i  (heads_q),
        .cols_o   (workload_cols),
        .mat_o    (mat_w),
        .head_o   (head_idx),
        .addr_o   (addr_w),
        .last_o   (last)
    );

    assign mat_sel     = mat_w;
    assign weight_base = addr_w;
    assign output_base = addr_w;
    assign pe_start    = (state_q == S_ISSUE) && !abort;
    assign done        = (state_q == S_DONE) && !abort;
    assign busy        = (state_q != S_IDLE);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_qkv_pass_scheduler.sv
// Directed bench for qkv_pass_scheduler with a 4-cycle PE-array model.
module tb_qkv_pass_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  num_heads;
    logic [15:0] size_of_wq;
    logic [7:0]  num_pes;
    logic [7:0]  num_macs;
    logic        pe_start;
    logic        pe_done_m;
    logic        pe_done_x;
    logic        pe_done_w;
    logic [15:0] workload_cols;
    logic [1:0]  mat_sel;
    logic [3:0]  head_idx;
    logic [7:0]  weight_base;
    logic [7:0]  output_base;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int nchk = 0;
    int nok  = 0;
    int cyc  = 0;
    int st_cyc;

    int ps_cyc [64];
    int ps_wc  [64];
    int ps_mat [64];
    int ps_head[64];
    int ps_wb  [64];
    int ps_ob  [64];
    int npass = 0;
    int pd_cyc [64];
    int pd_wc  [64];
    int npd = 0;
    int ndone = 0;
    int done_cyc = 0;
    logic done_cfg = 1'b0;
    logic done_busy = 1'b0;

    int t2wc[6] = '{16, 4, 16, 4, 16, 4};
    int t2wb[6] = '{0, 16, 20, 36, 40, 56};
    int t2mt[6] = '{0, 0, 1, 1, 2, 2};

    assign pe_done_w = pe_done_m | pe_done_x;

    qkv_pass_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_heads     (num_heads),
        .size_of_wq    (size_of_wq),
        .num_pes       (num_pes),
        .num_macs      (num_macs),
        .pe_start      (pe_start),
        .pe_done       (pe_done_w),
        .workload_cols (workload_cols),
        .mat_sel       (mat_sel),
        .head_idx      (head_idx),
        .weight_base   (weight_base),
        .output_base   (output_base),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pe_start) begin
            ps_cyc[npass]  = cyc;
            ps_wc[npass]   = int'(workload_cols);
            ps_mat[npass]  = int'(mat_sel);
            ps_head[npass] = int'(head_idx);
            ps_wb[npass]   = int'(weight_base);
            ps_ob[npass]   = int'(output_base);
            npass++;
        end
        if (done) begin
            done_cyc  = cyc;
            done_cfg  = cfg_err;
            done_busy = busy;
            ndone++;
        end
    end

    // PE array: answers each pe_start with pe_done four cycles later
    initial begin
        pe_done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (pe_start) begin
                repeat (4) @(negedge clk);
                #1;
                pe_done_m  = 1'b1;
                pd_cyc[npd] = cyc;
                pd_wc[npd]  = int'(workload_cols);
                npd++;
                @(negedge clk);
                #1;
                pe_done_m = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got === exp) nok++;
        else $display("FAIL %s got %0d want %0d", tag, got, exp);
    endtask

    task automatic go(input logic [3:0] h, input logic [15:0] sz,
                      input logic [7:0] p, input logic [7:0] m);
        num_heads  = h;
        size_of_wq = sz;
        num_pes    = p;
        num_macs   = m;
        start      = 1'b1;
        st_cyc     = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n;
        n = 0;
        while (ndone == d0 && n < 400) begin
            tick;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(ndone > d0), 1);
    endtask

    task automatic wait_pass(input string tag, input int b, input int k);
        int n;
        n = 0;
        while (npass - b < k && n < 200) begin
            tick;
            n++;
        end
        chk({tag, "_pass_seen"}, 32'(npass - b >= k), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pe_start"}, 32'(pe_start), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_wc"}, 32'(workload_cols), 0);
        chk({tag, "_mat"}, 32'(mat_sel), 0);
        chk({tag, "_head"}, 32'(head_idx), 0);
        chk({tag, "_wb"}, 32'(weight_base), 0);
        chk({tag, "_ob"}, 32'(output_base), 0);
    endtask

    task automatic chk_t1(input string tag, input int b, input int d0);
        chk({tag, "_npass"}, npass - b, 6);
        chk({tag, "_ndone"}, ndone - d0, 1);
        chk({tag, "_lat0"}, ps_cyc[b] - st_cyc, 2);
        chk({tag, "_latd"}, done_cyc - pd_cyc[b+5], 2);
        chk({tag, "_dbusy"}, 32'(done_busy), 1);
        chk({tag, "_dcfg"}, 32'(done_cfg), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_wc%0d", tag, k), ps_wc[b+k], 8);
            chk($sformatf("%s_hold%0d", tag, k), pd_wc[b+k], 8);
            chk($sformatf("%s_mat%0d", tag, k), ps_mat[b+k], k % 3);
            chk($sformatf("%s_head%0d", tag, k), ps_head[b+k], k / 3);
            chk($sformatf("%s_wb%0d", tag, k), ps_wb[b+k], 8 * k);
            chk($sformatf("%s_ob%0d", tag, k), ps_ob[b+k], 8 * k);
            if (k > 0)
                chk($sformatf("%s_lat%0d", tag, k),
                    ps_cyc[b+k] - pd_cyc[b+k-1], 2);
        end
    endtask

    initial begin
        int b;
        int d0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_heads  = '0;
        size_of_wq = '0;
        num_pes    = '0;
        num_macs   = '0;
        pe_done_x  = 1'b0;
        tick;
        tick;
        chk_zero("rst");
        rst_n = 1'b1;
        tick;
        tick;

        // stray pe_done while idle
        b = npass;
        pe_done_x = 1'b1;
        tick;
        pe_done_x = 1'b0;
        tick;
        chk("idle_pd_busy", 32'(busy), 0);
        chk("idle_pd_npass", npass - b, 0);

        // two heads, one tile per matrix
        b = npass;
        d0 = ndone;
        go(4'd2, 16'd8, 8'd4, 8'd4);
        wait_done("t1", d0);
        repeat (3) tick;
        chk_t1("t1", b, d0);

        // remainder tiles: 20 columns over a 16-wide array
        b = npass;
        d0 = ndone;
        go(4'd1, 16'd20, 8'd4, 8'd4);
        wait_done("t2", d0);
        repeat (3) tick;
        chk("t2_npass", npass - b, 6);
        chk("t2_ndone", ndone - d0, 1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_wc%0d", k), ps_wc[b+k], t2wc[k]);
            chk($sformatf("t2_mat%0d", k), ps_mat[b+k], t2mt[k]);
            chk($sformatf("t2_head%0d", k), ps_head[b+k], 0);
            chk($sformatf("t2_wb%0d", k), ps_wb[b+k], t2wb[k]);
        end

        // illegal configurations
        b = npass;
        d0 = ndone;
        go(4'd0, 16'd8, 8'd4, 8'd4);
        wait_done("e0", d0);
        chk("e0_lat", done_cyc - st_cyc, 2);
        chk("e0_dcfg", 32'(done_cfg), 1);
        repeat (5) tick;
        chk("e0_sticky", 32'(cfg_err), 1);
        chk("e0_npass", npass - b, 0);
        d0 = ndone;
        go(4'd2, 16'd8, 8'd0, 8'd4);
        wait_done("e1", d0);
        chk("e1_lat", done_cyc - st_cyc, 2);
        chk("e1_dcfg", 32'(done_cfg), 1);
        repeat (5) tick;
        chk("e1_sticky", 32'(cfg_err), 1);
        chk("e1_npass", npass - b, 0);
        d0 = ndone;
        go(4'd1, 16'd8, 8'd4, 8'd4);
        chk("e2_clear", 32'(cfg_err), 0);
        wait_done("e2", d0);
        chk("e2_dcfg", 32'(done_cfg), 0);
        chk("e2_npass", npass - b, 3);

        // abort in the third WAIT, then a clean restart
        repeat (3) tick;
        b = npass;
        d0 = ndone;
        go(4'd2, 16'd8, 8'd4, 8'd4);
        wait_pass("ab", b, 3);
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_pe_start", 32'(pe_start), 0);
        repeat (10) tick;
        chk("ab_npass", npass - b, 3);
        chk("ab_ndone", ndone - d0, 0);
        chk("ab_idle", 32'(busy), 0);
        b = npass;
        go(4'd2, 16'd8, 8'd4, 8'd4);
        wait_done("ab2", d0);
        repeat (3) tick;
        chk_t1("ab2", b, d0);

        // pe_done during ISSUE and a second start while busy
        b = npass;
        d0 = ndone;
        go(4'd2, 16'd8, 8'd4, 8'd4);
        wait_pass("sp", b, 1);
        pe_done_x = 1'b1;
        tick;
        pe_done_x = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done("sp", d0);
        repeat (8) tick;
        chk_t1("sp", b, d0);

        // asynchronous reset during WAIT
        b = npass;
        d0 = ndone;
        go(4'd2, 16'd8, 8'd4, 8'd4);
        wait_pass("rw", b, 2);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rw");
        tick;
        rst_n = 1'b1;
        repeat (15) tick;
        chk("rw_npass", npass - b, 2);
        chk("rw_ndone", ndone - d0, 0);
        chk("rw_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", nok, nchk);
        $finish;
    end

endmodule
